// File: rtl/ddr_port1_frame_reader.sv
// Purpose: reads one stored frame from DDR through MCB port 1 and streams it out as 32-bit words.
// Latency: frame_start -> read command one cycle later; FIFO head -> pixel_data one cycle after the pop.
// Backpressure: commands wait while p1_cmd_full; the read FIFO is popped only when the output register is free or being accepted.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   mem_calib_done      MCB calibration flag (asynchronous, synchronised here)
//   frame_start         one-cycle request to read a frame from BASE_ADDR
//   p1_cmd_*            MCB port-1 command interface (read bursts only)
//   p1_rd_*             MCB port-1 read FIFO (first-word fall-through)
//   pixel_*             word stream to the pixel pipeline (valid/ready)
//   frame_done          one-cycle pulse once the last word has been accepted
//   busy, rd_error      frame-in-progress flag and sticky read-FIFO overflow flag
//   state_dbg           current state encoding for the LED display
module ddr_port1_frame_reader #(
  parameter int unsigned FRAME_WORDS = 70560,
  parameter logic [29:0] BASE_ADDR   = 30'd0,
  parameter int unsigned BURST_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_calib_done,
  input  logic        frame_start,
  input  logic        p1_cmd_full,
  output logic        p1_cmd_en,
  output logic [2:0]  p1_cmd_instr,
  output logic [5:0]  p1_cmd_bl,
  output logic [29:0] p1_cmd_byte_addr,
  input  logic [31:0] p1_rd_data,
  input  logic        p1_rd_empty,
  input  logic        p1_rd_overflow,
  output logic        p1_rd_en,
  output logic [31:0] pixel_data,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        frame_done,
  output logic        busy,
  output logic        rd_error,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    ST_CALIB = 4'd0,
    ST_IDLE  = 4'd1,
    ST_CMD   = 4'd2,
    ST_DRAIN = 4'd3,
    ST_DONE  = 4'd4
  } state_t;

  typedef struct packed {
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] byte_addr;
  } rd_cmd_t;

  localparam logic [23:0] FRAME_L  = 24'(FRAME_WORDS);
  localparam logic [6:0]  BURST_L  = 7'(BURST_WORDS);
  localparam logic [2:0]  CMD_READ = 3'b001;

  // Calibration synchroniser
  logic calib_meta_q;
  logic calib_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_meta_q <= 1'b0;
      calib_sync_q <= 1'b0;
    end else begin
      calib_meta_q <= mem_calib_done;
      calib_sync_q <= calib_meta_q;
    end
  end

  // State and datapath registers
  state_t      state_q,       state_d;
  logic [29:0] addr_q,        addr_d;
  logic [23:0] words_left_q,  words_left_d;
  logic [6:0]  burst_left_q,  burst_left_d;
  logic        pending_q,     pending_d;
  logic        busy_q,        busy_d;
  logic [31:0] pixel_data_q,  pixel_data_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic        rd_error_q,    rd_error_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_CALIB;
      addr_q        <= 30'd0;
      words_left_q  <= 24'd0;
      burst_left_q  <= 7'd0;
      pending_q     <= 1'b0;
      busy_q        <= 1'b0;
      pixel_data_q  <= 32'd0;
      pixel_valid_q <= 1'b0;
      rd_error_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      words_left_q  <= words_left_d;
      burst_left_q  <= burst_left_d;
      pending_q     <= pending_d;
      busy_q        <= busy_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      rd_error_q    <= rd_error_d;
    end
  end

  // Size of the next burst: the final burst of a frame may be short.
  logic [6:0] burst;

  always_comb begin
    burst = BURST_L;
    if (words_left_q < {17'd0, BURST_L}) begin
      burst = words_left_q[6:0];
    end
  end

  // The output register can take a new word when it is empty or its word
  // leaves this cycle, which gives one word per cycle at full rate.
  logic pop;
  logic accept;

  assign accept = pixel_valid_q && pixel_ready;
  assign pop    = (state_q == ST_DRAIN) && !p1_rd_empty && (burst_left_q != 7'd0)
               && (!pixel_valid_q || pixel_ready);

  rd_cmd_t cmd;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    words_left_d  = words_left_q;
    burst_left_d  = burst_left_q;
    pending_d     = pending_q;
    busy_d        = busy_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = pixel_valid_q;
    rd_error_d    = rd_error_q | p1_rd_overflow;
    cmd           = '0;
    p1_cmd_en     = 1'b0;
    frame_done    = 1'b0;

    // A request during a frame is remembered, never aborts; repeats collapse.
    if (frame_start && busy_q) begin
      pending_d = 1'b1;
    end

    if (pop) begin
      pixel_data_d  = p1_rd_data;
      pixel_valid_d = 1'b1;
      burst_left_d  = burst_left_q - 7'd1;
    end else if (accept) begin
      pixel_valid_d = 1'b0;
    end

    case (state_q)
      ST_CALIB: begin
        if (calib_sync_q) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (frame_start || pending_q) begin
          addr_d       = BASE_ADDR;
          words_left_d = FRAME_L;
          pending_d    = 1'b0;
          busy_d       = 1'b1;
          state_d      = ST_CMD;
        end
      end

      ST_CMD: begin
        cmd.instr     = CMD_READ;
        cmd.bl        = 6'(burst - 7'd1);
        cmd.byte_addr = addr_q;
        if (!p1_cmd_full) begin
          p1_cmd_en    = 1'b1;
          // Address arithmetic wraps modulo 2^30 by construction.
          addr_d       = addr_q + {21'd0, burst, 2'b00};
          words_left_d = words_left_q - {17'd0, burst};
          burst_left_d = burst;
          state_d      = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Only one burst is ever outstanding: the next command waits until
        // every word of this one has been popped.
        if (burst_left_d == 7'd0) begin
          state_d = (words_left_q != 24'd0) ? ST_CMD : ST_DONE;
        end
      end

      ST_DONE: begin
        // The frame ends once the final word has left the output register.
        if (!pixel_valid_q) begin
          frame_done = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_CALIB;
      end
    endcase
  end

  assign p1_cmd_instr     = cmd.instr;
  assign p1_cmd_bl        = cmd.bl;
  assign p1_cmd_byte_addr = cmd.byte_addr;
  assign p1_rd_en         = pop;
  assign pixel_data       = pixel_data_q;
  assign pixel_valid      = pixel_valid_q;
  assign busy             = busy_q;
  assign rd_error         = rd_error_q;
  assign state_dbg        = state_q;

endmodule
